mux2_stream_arbiter: RTL and testbench
======================================

// Module: mux2_stream_arbiter
// PURPOSE
//  Stage that drives the select of a 2:1 mux. It owns the arbitration and
//  registers the result for the consumer.
//  It takes two valid/ready input streams (d0, d1) and produces one output
//  stream (y). The s output is driven by a round-robin arbiter with
//  burst-hold.
//  The block sits between two producers and a single consumer. It
//  replaces a free-running select with a handshaken, fair, 1-cycle
//  registered mux path.
// PARAMETERS
//  WIDTH      8  data width of d0_data, d1_data and y_data
//  MAX_BURST  4  max consecutive transfers granted to one input while the
//                other input waits; legal range 1..255
// PORTS
//  clk       input   1      single clock; all state updates on rising edge
//  rst_n     input   1      asynchronous, active-low reset
//  d0_valid  input   1      input 0 has data
//  d0_data   input   WIDTH  input 0 payload
//  d0_ready  output  1      input 0 transfer accepted this cycle
//  d1_valid  input   1      input 1 has data
//  d1_data   input   WIDTH  input 1 payload
//  d1_ready  output  1      input 1 transfer accepted this cycle
//  y_valid   output  1      registered output holds data
//  y_data    output  WIDTH  registered output payload
//  y_ready   input   1      consumer accepts y this cycle
//  s         output  1      current grant: 0 = d0, 1 = d1 (combinational from FSM state)
// BEHAVIOUR
//  Reset (rst_n low, async):
//   - state=IDLE, s=0, burst_cnt=0, last_served=1 (so d0 wins the first tie)
//   - y_valid=0, y_data=0; d0_ready=d1_ready=0 while in IDLE
//   - Reset mid-burst or with y_valid=1 discards held data; no partial transfer survives.
//  Output register:
//   - space = !y_valid | y_ready.
//   - dX_ready = (state==GRANTX) & space; a transfer is dX_valid & dX_ready.
//   - On a transfer: y_data <= dX_data and y_valid <= 1.
//   - Else if y_ready: y_valid <= 0.
//   - Latency is 1 cycle from input transfer to y_valid. Full throughput is
//     1 word/cycle while y_ready=1.
//   - y_data/y_valid stay stable while y_valid & !y_ready.
//  FSM states: IDLE, GRANT0, GRANT1. s=1 only in GRANT1.
//   IDLE:
//    - only d0_valid -> GRANT0; only d1_valid -> GRANT1
//    - both valid -> the input != last_served; neither valid -> stay IDLE
//    - The grant takes effect the next cycle; IDLE accepts nothing (1 bubble).
//   GRANTx, on each transfer:
//    - burst_cnt++ and last_served<=x.
//    - Switch to the other input when the other input is valid and either
//      burst_cnt+1==MAX_BURST or !dx_valid on the following cycle.
//   GRANTx, no transfer:
//    - !dx_valid & other valid -> GRANT other
//    - !dx_valid & other idle -> IDLE
//    - dx_valid blocked by !space -> hold (no switch while backpressured with a request pending)
//   Any state change clears burst_cnt to 0.
//   When burst_cnt reaches MAX_BURST and the other input is idle, keep the
//   grant and wrap burst_cnt to 0.
//   Simultaneous switch and transfer: the transfer completes under the old
//   grant; the new grant starts next cycle.
//  Widths: burst_cnt is $clog2(MAX_BURST+1) bits. No arithmetic on data; pass-through only.
//  Inputs must hold dX_valid/dX_data until accepted (standard valid/ready).
//  The block does not check this.
// TESTING
//  1. Reset: hold rst_n=0 with d0_valid=1, y_ready=1
//     -> y_valid=0, s=0, d0_ready=0. Release; d0_data=8'hA5
//     -> d0_ready=1 at cycle 2, y_data=A5 and y_valid=1 at cycle 3.
//  2. Both streams always valid, y_ready=1, MAX_BURST=4, d0=0x10.., d1=0x20..
//     -> y sequence 10,11,12,13,20,21,22,23,14,.. with s toggling every 4 transfers.
//  3. Backpressure: y_ready=0 for 5 cycles with y_valid=1
//     -> y_data stable, d0_ready=d1_ready=0, no grant change.
//     Then y_ready=1 -> flow resumes with no lost or duplicated word.
//  4. Only d1 valid for 10 words
//     -> all 10 words pass, s=1 throughout, burst_cnt wraps, and d0_ready stays 0.
//  5. d0 drops valid after 2 words while d1 is valid
//     -> grant moves to d1 with burst_cnt=0. The d0 request reappears one
//     cycle later and is served only after d1's burst of 4.
//  6. Assert rst_n=0 mid-burst with y_valid=1
//     -> y_valid drops immediately (async) and the FSM returns to IDLE.
//     After release, a tie grants d0 first.

Source files
------------

// File: rtl/mux2_stream_arbiter.sv
// Two-input valid/ready stream mux with a registered output stage and a
// round-robin select that lets one input hold the grant for up to MAX_BURST words.
`timescale 1ns/1ps

module mux2_stream_arbiter #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             d0_valid_i,
    input  logic [WIDTH-1:0] d0_data_i,
    output logic             d0_ready_o,
    input  logic             d1_valid_i,
    input  logic [WIDTH-1:0] d1_data_i,
    output logic             d1_ready_o,
    output logic             y_valid_o,
    output logic [WIDTH-1:0] y_data_o,
    input  logic             y_ready_i,
    output logic             s_o
);

    localparam int unsigned CntW = $clog2(MAX_BURST + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(MAX_BURST - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CntW-1:0]    burst_cnt_q, burst_cnt_d;
    logic               last_served_q, last_served_d;
    logic               y_valid_q, y_valid_d;
    logic [WIDTH-1:0]   y_data_q, y_data_d;

    logic               space;
    logic               granted;
    logic               grant_sel;
    logic               grant_valid;
    logic               other_valid;
    logic               xfer;

    // The output register has room when it is empty or being drained this cycle.
    always_comb begin
        space       = !y_valid_q || y_ready_i;
        granted     = (state_q == GRANT0) || (state_q == GRANT1);
        grant_sel   = (state_q == GRANT1);
        grant_valid = grant_sel ? d1_valid_i : d0_valid_i;
        other_valid = grant_sel ? d0_valid_i : d1_valid_i;
        xfer        = granted && grant_valid && space;
    end

    assign d0_ready_o = (state_q == GRANT0) && space;
    assign d1_ready_o = (state_q == GRANT1) && space;
    assign s_o        = grant_sel;
    assign y_valid_o  = y_valid_q;
    assign y_data_o   = y_data_q;

    always_comb begin
        state_d       = state_q;
        burst_cnt_d   = burst_cnt_q;
        last_served_d = last_served_q;

        unique case (state_q)
            IDLE: begin
                burst_cnt_d = '0;
                if (d0_valid_i && d1_valid_i) begin
                    state_d = last_served_q ? GRANT0 : GRANT1;
                end else if (d0_valid_i) begin
                    state_d = GRANT0;
                end else if (d1_valid_i) begin
                    state_d = GRANT1;
                end
            end

            GRANT0, GRANT1: begin
                if (xfer) begin
                    last_served_d = grant_sel;
                    // A full burst either hands over or, with no contender, restarts the count.
                    if (burst_cnt_q == CntLast) begin
                        burst_cnt_d = '0;
                        if (other_valid) begin
                            state_d = grant_sel ? GRANT0 : GRANT1;
                        end
                    end else begin
                        burst_cnt_d = burst_cnt_q + CntW'(1);
                    end
                end else if (!grant_valid) begin
                    burst_cnt_d = '0;
                    if (other_valid) begin
                        state_d = grant_sel ? GRANT0 : GRANT1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end

            default: begin
                state_d     = IDLE;
                burst_cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        y_valid_d = y_valid_q;
        y_data_d  = y_data_q;
        if (xfer) begin
            y_valid_d = 1'b1;
            y_data_d  = grant_sel ? d1_data_i : d0_data_i;
        end else if (y_ready_i) begin
            y_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            burst_cnt_q   <= '0;
            last_served_q <= 1'b1;
            y_valid_q     <= 1'b0;
            y_data_q      <= '0;
        end else begin
            state_q       <= state_d;
            burst_cnt_q   <= burst_cnt_d;
            last_served_q <= last_served_d;
            y_valid_q     <= y_valid_d;
            y_data_q      <= y_data_d;
        end
    end

endmodule

// File: tb/tb_mux2_stream_arbiter.sv
// Randomized bench for mux2_stream_arbiter: a grant-policy model predicts readies
// and select, and a scoreboard queue of accepted words is checked against the output.
`timescale 1ns/1ps

module tb_mux2_stream_arbiter;

    localparam int WIDTH     = 8;
    localparam int MAX_BURST = 4;
    localparam int NPHASE    = 7;

    logic             clk;
    logic             rst_n;
    logic             vld [2];
    logic [WIDTH-1:0] dat [2];
    logic             yReady;
    logic             d0Ready;
    logic             d1Ready;
    logic             yValid;
    logic [WIDTH-1:0] yData;
    logic             sel;

    int compared   = 0;
    int mismatched = 0;

    // Reference state: who holds the grant (-1 none), words in the current burst,
    // the last input served and whether the output register holds a word.
    int mGrant  = -1;
    int mBurst  = 0;
    int mLast   = 1;
    int mHeld   = 0;
    bit acc [2] = '{0, 0};
    int seq [2] = '{0, 0};
    logic [WIDTH-1:0] sbQ [$];

    int phCycles [NPHASE] = '{40, 6, 30, 200, 200, 100, 12};
    int phP0     [NPHASE] = '{100, 100, 0, 50, 70, 20, 0};
    int phP1     [NPHASE] = '{100, 100, 100, 50, 30, 20, 0};
    int phReady  [NPHASE] = '{100, 0, 100, 70, 50, 100, 100};
    int phReset  [NPHASE] = '{-1, -1, -1, 100, 57, -1, -1};

    mux2_stream_arbiter #(
        .WIDTH     (WIDTH),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .d0_valid_i (vld[0]),
        .d0_data_i  (dat[0]),
        .d0_ready_o (d0Ready),
        .d1_valid_i (vld[1]),
        .d1_data_i  (dat[1]),
        .d1_ready_o (d1Ready),
        .y_valid_o  (yValid),
        .y_data_o   (yData),
        .y_ready_i  (yReady),
        .s_o        (sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic resetModel();
        mGrant = -1;
        mBurst = 0;
        mLast  = 1;
        mHeld  = 0;
        acc[0] = 1'b0;
        acc[1] = 1'b0;
        sbQ.delete();
    endtask

    // Producers hold a word until it is accepted, then may offer the next one.
    task automatic applyStimulus(input int p0, input int p1, input int pr);
        int pv [2];
        pv[0] = p0;
        pv[1] = p1;
        for (int i = 0; i < 2; i++) begin
            if (vld[i] && acc[i]) vld[i] = 1'b0;
            acc[i] = 1'b0;
            if (!vld[i] && ($urandom_range(0, 99) < pv[i])) begin
                vld[i] = 1'b1;
                dat[i] = WIDTH'((i * 128) + (seq[i] % 128));
                seq[i]++;
            end
        end
        yReady = ($urandom_range(0, 99) < pr);
    endtask

    // Compare the handshake outputs with the model, then advance the model one cycle.
    task automatic checkOutput();
        bit space;
        bit xfer;
        int other;
        space = (mHeld == 0) || yReady;
        check("d0_ready", d0Ready, (mGrant == 0) && space);
        check("d1_ready", d1Ready, (mGrant == 1) && space);
        check("s", sel, mGrant == 1);
        check("y_valid", yValid, mHeld);
        xfer = 1'b0;
        if (mGrant >= 0) xfer = vld[mGrant] && space;
        if (mGrant < 0) begin
            if (vld[0] && vld[1]) mGrant = 1 - mLast;
            else if (vld[0])      mGrant = 0;
            else if (vld[1])      mGrant = 1;
            mBurst = 0;
        end else begin
            other = 1 - mGrant;
            if (xfer) begin
                sbQ.push_back(dat[mGrant]);
                acc[mGrant] = 1'b1;
                mLast = mGrant;
                mBurst++;
                if (mBurst == MAX_BURST) begin
                    mBurst = 0;
                    if (vld[other]) mGrant = other;
                end
            end else if (!vld[mGrant]) begin
                mBurst = 0;
                mGrant = vld[other] ? other : -1;
            end
        end
        mHeld = xfer ? 1 : (yReady ? 0 : mHeld);
    endtask

    // Asynchronous reset between clock edges must clear the output at once.
    task automatic doReset();
        rst_n = 1'b0;
        #1;
        check("rst_y_valid", yValid, 1'b0);
        check("rst_s", sel, 1'b0);
        check("rst_d0_ready", d0Ready, 1'b0);
        check("rst_d1_ready", d1Ready, 1'b0);
        resetModel();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: every accepted output word must be the oldest accepted input word.
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (rst_n && yValid && yReady) begin
                if (sbQ.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL y_data: got %0h expected nothing (queue empty) at %0t", yData, $time);
                end else begin
                    check("y_data", yData, sbQ.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n  = 1'b0;
        vld[0] = 1'b1;
        dat[0] = 8'hA5;
        vld[1] = 1'b0;
        dat[1] = '0;
        yReady = 1'b1;
        seq[0] = 1;
        resetModel();
        @(negedge clk);
        #1;
        check("por_y_valid", yValid, 1'b0);
        check("por_s", sel, 1'b0);
        check("por_d0_ready", d0Ready, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput();
        for (int p = 0; p < NPHASE; p++) begin
            for (int c = 0; c < phCycles[p]; c++) begin
                @(negedge clk);
                applyStimulus(phP0[p], phP1[p], phReady[p]);
                if (c == phReset[p]) doReset();
                #1;
                checkOutput();
            end
        end
        @(negedge clk);
        #4;
        check("scoreboard_empty", sbQ.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
